tt_sweep_ctrl: RTL and testbench

Sequencer for exhaustively exercising a 4-input, 1-output combinational unit such as the lab adder/function blocks. On `start` it drives all 16 input vectors in ascending binary order and holds each for a programmable settle time. It samples the unit's output into a 16-bit truth-table register and counts the ones. It sits between a control source (switches, a bench or a host FSM) and the combinational unit under exercise, replacing hand-written vector sequences.

---
 rtl/tt_sweep_ctrl_if.sv | 16 +
 rtl/tt_sweep_ctrl.sv | 103 ++++++++++
 tb/tb_tt_sweep_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tt_sweep_ctrl_if.sv
// Signal bundle between a sweep controller and its host / unit under exercise.
// The host drives start and the unit's output; the controller returns vector and results.
interface tt_sweep_ctrl_if;
    logic        start;
    logic        f_in;
    logic [3:0]  x;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic [4:0]  ones_cnt;

    modport master (output start, output f_in,
                    input  x, input busy, input done, input tt, input ones_cnt);
    modport slave  (input  start, input f_in,
                    output x, output busy, output done, output tt, output ones_cnt);
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Drives all 16 vectors of a 4-input combinational unit, holds each SETTLE cycles,
// and captures the sampled output into a truth table with a population count.
module tt_sweep_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    tt_sweep_ctrl_if.slave  bus
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("tt_sweep_ctrl: SETTLE must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      tt_q, tt_d;
    logic [4:0]       ones_q, ones_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sample;

    assign sample = (state_q == SWEEP) && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SWEEP;
            SWEEP:   if (sample && x_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are registered: this block only computes their next values.
    always_comb begin
        x_d    = x_q;
        cnt_d  = cnt_q;
        tt_d   = tt_q;
        ones_d = ones_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d    = '0;
                    cnt_d  = '0;
                    tt_d   = '0;
                    ones_d = '0;
                    busy_d = 1'b1;
                end
            end
            SWEEP: begin
                if (sample) begin
                    tt_d[x_q] = bus.f_in;
                    ones_d    = ones_q + {4'd0, bus.f_in};
                    cnt_d     = '0;
                    if (x_q == 4'd15) begin
                        x_d    = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        x_d = x_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.x        = x_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tt       = tt_q;
    assign bus.ones_cnt = ones_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three instances (SETTLE 2, 1, 3) driven by behavioural
// function units, checked cycle by cycle against a table/mask reference model.
module tb_tt_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0]       start_r = '0;
    int               mode [3];
    logic [15:0]      rtab = '0;
    logic             tog = 1'b0;
    logic [2:0][3:0]  x_w;
    logic [2:0]       busy_w, done_w;
    logic [2:0][15:0] tt_w;
    logic [2:0][4:0]  ones_w;

    always @(posedge clk) tog <= ~tog;

    // mode: 0 parity, 1 const 0, 2 const 1, 3 registered (x==5), 4 random table, 5 toggling
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        tt_sweep_ctrl_if ifc ();
        logic fdel = 1'b0;
        always @(posedge clk) fdel <= (ifc.x == 4'd5);
        assign ifc.start = start_r[g];
        assign ifc.f_in  = (mode[g] == 0) ? ^ifc.x :
                           (mode[g] == 1) ? 1'b0 :
                           (mode[g] == 2) ? 1'b1 :
                           (mode[g] == 3) ? fdel :
                           (mode[g] == 4) ? rtab[ifc.x] : tog;
        assign x_w[g]    = ifc.x;
        assign busy_w[g] = ifc.busy;
        assign done_w[g] = ifc.done;
        assign tt_w[g]   = ifc.tt;
        assign ones_w[g] = ifc.ones_cnt;
        tt_sweep_ctrl #(.SETTLE(S)) u_dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 3;
    endfunction

    function automatic logic [15:0] parity_table();
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = ($countones(v) % 2) == 1;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input int d, input string tag, input logic [3:0] ex,
                           input logic eb, input logic ed, input logic [15:0] et);
        chk($sformatf("%s x", tag), {28'd0, x_w[d]}, {28'd0, ex});
        chk($sformatf("%s busy", tag), {31'd0, busy_w[d]}, {31'd0, eb});
        chk($sformatf("%s done", tag), {31'd0, done_w[d]}, {31'd0, ed});
        chk($sformatf("%s tt", tag), {16'd0, tt_w[d]}, {16'd0, et});
        chk($sformatf("%s ones", tag), {27'd0, ones_w[d]}, $countones(et));
    endtask

    // Full sweep from IDLE. Expected tt after k edges holds only vectors v whose
    // sample edge (v+1)*S has passed. Optional extra start pulses at edge rep and in DONE.
    task automatic run_sweep(input int d, input logic [15:0] exp, input int rep,
                             input bit pulse_done, input string tag);
        int s;
        logic [15:0] mask;
        s = settle_of(d);
        start_r[d] = 1'b1;
        @(posedge clk); #1;
        start_r[d] = 1'b0;
        chk_all(d, $sformatf("%s k0", tag), 4'd0, 1'b1, 1'b0, 16'h0000);
        for (int k = 1; k <= 16 * s + 1; k++) begin
            start_r[d] = (k == rep) || (pulse_done && k == 16 * s + 1);
            @(posedge clk); #1;
            start_r[d] = 1'b0;
            mask = '0;
            for (int v = 0; v < 16; v++) if ((v + 1) * s <= k) mask[v] = 1'b1;
            chk_all(d, $sformatf("%s k%0d", tag, k),
                    (k < 16 * s) ? 4'(k / s) : 4'd0,
                    k < 16 * s, k == 16 * s, exp & mask);
        end
    endtask

    initial begin
        int d, s;
        logic [15:0] fin;
        mode[0] = 0; mode[1] = 1; mode[2] = 3;

        #1;
        for (int i = 0; i < 3; i++)
            chk_all(i, $sformatf("reset d%0d", i), 4'd0, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        run_sweep(0, parity_table(), 0, 1'b0, "parity");
        mode[1] = 1;
        run_sweep(1, 16'h0000, 0, 1'b0, "const0");
        mode[1] = 2;
        run_sweep(1, 16'hFFFF, 0, 1'b0, "const1");
        mode[2] = 3;
        run_sweep(2, 16'h0020, 0, 1'b0, "regmodel");

        mode[0] = 4;
        rtab = 16'($urandom);
        run_sweep(0, rtab, 10, 1'b1, "restart_ign");
        rtab = 16'($urandom);
        run_sweep(0, rtab, 0, 1'b0, "next_idle");

        for (int it = 0; it < 6; it++) begin
            d = int'($urandom_range(0, 2));
            s = settle_of(d);
            mode[d] = 4;
            rtab = 16'($urandom);
            run_sweep(d, rtab, int'($urandom_range(1, 16 * s - 1)), it[0],
                      $sformatf("rand%0d", it));
        end

        mode[0] = 4;
        rtab = 16'($urandom);
        start_r[0] = 1'b1;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("arst pre x", {28'd0, x_w[0]}, 32'd7);
        #2 rst = 1'b1;
        #1;
        chk_all(0, "arst async", 4'd0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1;
            chk_all(0, $sformatf("arst idle%0d", k), 4'd0, 1'b0, 1'b0, 16'h0000);
        end
        rtab = 16'($urandom);
        run_sweep(0, rtab, 0, 1'b0, "post_arst");

        mode[1] = 4;
        rtab = 16'($urandom);
        fin = rtab;
        run_sweep(1, fin, 0, 1'b0, "hold_src");
        mode[1] = 5;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            chk_all(1, $sformatf("hold%0d", k), 4'd0, 1'b0, 1'b0, fin);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
